id_gen: RTL and testbench

Identifier stream generator: on request, emits one ASCII token of the form <letters><decimal digits><separator>, one character per handshake.
- Letters run 'a'/'A' upward; digits are a fixed-width BCD sequence number that increments after every token.
- Drives character-stream consumers (identifier/lexer checkers) and serves as a stimulus source for them.

---
 rtl/id_gen_pkg.sv | 21 ++
 rtl/id_gen_bcd_counter.sv | 36 +++
 rtl/id_gen.sv | 130 +++++++++++++
 tb/tb_id_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_gen_pkg.sv
// Shared constants and state encoding for the identifier stream generator.
package id_gen_pkg;

  localparam logic [7:0] CH_LA   = 8'd97;
  localparam logic [7:0] CH_UA   = 8'd65;
  localparam logic [7:0] CH_0    = 8'd48;
  localparam logic [4:0] ALPHA_N = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALPHA = 2'b01,
    ST_DIGIT = 2'b10,
    ST_SEP   = 2'b11
  } state_e;

  // Letter index runs up to 30, so a single subtraction is enough for mod 26.
  function automatic logic [4:0] wrap_letter(input logic [4:0] idx);
    return (idx >= ALPHA_N) ? idx - ALPHA_N : idx;
  endfunction

endpackage

// File: rtl/id_gen_bcd_counter.sv
// Fixed-width BCD counter: each digit carries at 9->0, all-9s wraps to zero.
module bcd_counter #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [4*NDIG-1:0] q
);

  logic [4*NDIG-1:0] q_q, q_d;
  logic              carry;

  always_comb begin
    q_d   = q_q;
    carry = inc;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          q_d[4*i +: 4] = 4'd0;
        end else begin
          q_d[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_gen.sv
// Emits <letters><NDIG BCD digits><separator>, one character per valid&&rdy handshake.
// Handshake: a character transfers on a clk edge where valid && rdy; char/valid hold while !rdy.
module id_gen
  import id_gen_pkg::*;
#(
  parameter int         NDIG     = 3,
  parameter logic [7:0] SEP_CHAR = 8'd32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        len,
  input  logic              upper,
  input  logic              rdy,
  output logic [7:0]        char_o,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] seq
);

  localparam logic [2:0] PTR_TOP = 3'(NDIG - 1);

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic       upper_q, upper_d;
  logic       done_q, done_d;
  logic       seq_inc;
  logic [3:0] nib;

  bcd_counter #(.NDIG(NDIG)) u_seq (
    .clk   (clk),
    .reset (reset),
    .inc   (seq_inc),
    .q     (seq)
  );

  // Output decode uses registered state only; rdy and start never reach char_o/valid.
  always_comb begin
    char_o = 8'd0;
    valid  = 1'b0;
    nib    = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (ptr_q == 3'(i)) nib = seq[4*i +: 4];
    end
    case (state_q)
      ST_ALPHA: begin
        valid  = 1'b1;
        char_o = (upper_q ? CH_UA : CH_LA) + {3'b000, wrap_letter(idx_q)};
      end
      ST_DIGIT: begin
        valid  = 1'b1;
        char_o = CH_0 + {4'b0000, nib};
      end
      ST_SEP: begin
        valid  = 1'b1;
        char_o = SEP_CHAR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    upper_d = upper_q;
    done_d  = 1'b0;
    seq_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (len == 5'd0) ? 5'd1 : len;
          upper_d = upper;
          idx_d   = 5'd0;
          state_d = ST_ALPHA;
        end
      end
      ST_ALPHA: begin
        if (rdy) begin
          if (idx_q == len_q - 5'd1) begin
            state_d = ST_DIGIT;
            ptr_d   = PTR_TOP;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_DIGIT: begin
        if (rdy) begin
          if (ptr_q == 3'd0) state_d = ST_SEP;
          else               ptr_d   = ptr_q - 3'd1;
        end
      end
      ST_SEP: begin
        if (rdy) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          seq_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= 5'd1;
      idx_q   <= 5'd0;
      ptr_q   <= 3'd0;
      upper_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      upper_q <= upper_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: default NDIG=3 instance plus an NDIG=1 instance for wrap.
module tb_id_gen;

  logic        clk = 1'b0;
  logic        reset, start0, start1, rdy, upper;
  logic [4:0]  len;
  logic [7:0]  char0, char1;
  logic        valid0, valid1, busy0, busy1, done0, done1;
  logic [11:0] seq0;
  logic [3:0]  seq1;

  int          checks = 0;
  int          passed = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic        timed_out;

  always #5 clk = ~clk;

  id_gen #(.NDIG(3), .SEP_CHAR(8'd32)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .len(len), .upper(upper), .rdy(rdy),
    .char_o(char0), .valid(valid0), .busy(busy0), .done(done0), .seq(seq0)
  );

  id_gen #(.NDIG(1), .SEP_CHAR(8'd32)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .len(len), .upper(upper), .rdy(rdy),
    .char_o(char1), .valid(valid1), .busy(busy1), .done(done1), .seq(seq1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_pulse(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Records transferred characters until the separator transfers; returns at the negedge after it.
  task automatic capture(input bit sel, input int budget);
    logic       v;
    logic [7:0] ch;
    got_q.delete();
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      v  = sel ? valid1 : valid0;
      ch = sel ? char1 : char0;
      @(negedge clk);
      if (v && rdy) begin
        got_q.push_back(ch);
        if (ch == 8'd32) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start0 = 0; start1 = 0; rdy = 0; upper = 0; len = 0;
    @(negedge clk);
    checks++;
    if ({char0, valid0, busy0, done0, seq0} !== {8'd0, 3'b000, 12'h000})
      $display("FAIL reset_dut0 got char=%0d valid=%b busy=%b done=%b seq=%h",
               char0, valid0, busy0, done0, seq0);
    else passed++;
    checks++;
    if ({char1, valid1, busy1, done1, seq1} !== {8'd0, 3'b000, 4'h0})
      $display("FAIL reset_dut1 got char=%0d valid=%b busy=%b done=%b seq=%h",
               char1, valid1, busy1, done1, seq1);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    len = 5'd3; upper = 1'b0; rdy = 1'b1;
    checks++;
    if (valid0 !== 1'b0) $display("FAIL basic_idle_valid got=%b exp=0", valid0);
    else passed++;
    start_pulse(0);
    checks++;
    if (valid0 !== 1'b1 || char0 !== 8'd97 || busy0 !== 1'b1)
      $display("FAIL basic_latency got valid=%b char=%0d busy=%b exp valid=1 char=97 busy=1",
               valid0, char0, busy0);
    else passed++;
    capture(0, 20);
    load_exp("abc000 ");
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size())
      $display("FAIL basic_len got=%0d exp=%0d timeout=%b", got_q.size(), exp_q.size(), timed_out);
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL basic_char[%0d] got=%0d exp=%0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      else passed++;
    end
    checks++;
    if (done0 !== 1'b1 || seq0 !== 12'h001 || busy0 !== 1'b0)
      $display("FAIL basic_done got done=%b seq=%h busy=%b exp done=1 seq=001 busy=0",
               done0, seq0, busy0);
    else passed++;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int gaps     = 0;
    bit seen     = 0;
    do_reset();
    len = 5'd1; upper = 1'b1; rdy = 1'b1;
    got_q.delete();
    start0 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done0) done_cnt++;
      if (valid0) begin
        seen = 1;
        got_q.push_back(char0);
      end else if (seen && done_cnt < 3) begin
        gaps++;
      end
      if (done_cnt == 3) break;
    end
    start0 = 1'b0;
    load_exp("A000 A001 A002 ");
    checks++;
    if (got_q.size() != exp_q.size() || done_cnt != 3)
      $display("FAIL b2b_len got=%0d exp=%0d done_pulses=%0d", got_q.size(), exp_q.size(), done_cnt);
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL b2b_char[%0d] got=%0d exp=%0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      else passed++;
    end
    checks++;
    if (gaps != 2) $display("FAIL b2b_gap got=%0d exp=2", gaps);
    else passed++;
    checks++;
    if (seq0 !== 12'h003) $display("FAIL b2b_seq got=%h exp=003", seq0);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    len = 5'd2; upper = 1'b0; rdy = 1'b1;
    start_pulse(0);
    checks++;
    if (char0 !== 8'd97) $display("FAIL bp_first got=%0d exp=97", char0);
    else passed++;
    @(negedge clk);
    rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (char0 !== 8'd98 || valid0 !== 1'b1)
        $display("FAIL bp_hold got char=%0d valid=%b exp char=98 valid=1", char0, valid0);
      else passed++;
    end
    rdy = 1'b1;
    capture(0, 20);
    load_exp("b000 ");
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size())
      $display("FAIL bp_len got=%0d exp=%0d timeout=%b", got_q.size(), exp_q.size(), timed_out);
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bp_char[%0d] got=%0d exp=%0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_len_edges();
    do_reset();
    rdy = 1'b1; upper = 1'b0;
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 5'd0 : 5'd28;
      start_pulse(0);
      capture(0, 60);
      if (t == 0) load_exp("a000 ");
      else        load_exp("abcdefghijklmnopqrstuvwxyzab001 ");
      checks++;
      if (timed_out !== 1'b0 || got_q.size() != exp_q.size())
        $display("FAIL len_edge%0d_len got=%0d exp=%0d timeout=%b", t, got_q.size(), exp_q.size(),
                 timed_out);
      else passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i])
          $display("FAIL len_edge%0d_char[%0d] got=%0d exp=%0d", t, i,
                   (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    rdy = 1'b1; upper = 1'b0; len = 5'd1;
    for (int t = 0; t < 11; t++) begin
      start_pulse(1);
      capture(1, 20);
      exp_q.delete();
      exp_q.push_back(8'd97);
      exp_q.push_back(8'(48 + (t % 10)));
      exp_q.push_back(8'd32);
      checks++;
      if (timed_out !== 1'b0 || got_q.size() != 3 || got_q[0] !== exp_q[0] ||
          got_q[1] !== exp_q[1] || got_q[2] !== exp_q[2])
        $display("FAIL wrap_token%0d got_size=%0d digit=%0d exp_digit=%0d", t, got_q.size(),
                 (got_q.size() > 1) ? got_q[1] : 8'hff, exp_q[1]);
      else passed++;
      checks++;
      if (seq1 !== 4'((t + 1) % 10))
        $display("FAIL wrap_seq%0d got=%h exp=%h", t, seq1, 4'((t + 1) % 10));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 1'b1; upper = 1'b0; len = 5'd1;
    start_pulse(0);
    capture(0, 20);
    start_pulse(0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (char0 !== 8'd48 || valid0 !== 1'b1 || seq0 !== 12'h001)
      $display("FAIL rmid_pre got char=%0d valid=%b seq=%h exp char=48 valid=1 seq=001",
               char0, valid0, seq0);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || seq0 !== 12'h000 || char0 !== 8'd0)
      $display("FAIL rmid_async got valid=%b busy=%b seq=%h char=%0d exp 0/0/000/0",
               valid0, busy0, seq0, char0);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_pulse(0);
    capture(0, 20);
    load_exp("a000 ");
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size())
      $display("FAIL rmid_len got=%0d exp=%0d timeout=%b", got_q.size(), exp_q.size(), timed_out);
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rmid_char[%0d] got=%0d exp=%0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_len_edges();
    test_seq_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
